// File: rtl/player_controller.sv
// Overworld player controller: per-frame movement with screen clamping, wild-grass
// encounter detection and the flash/battle hand-off sequence.
module player_controller #(
    parameter int STEP         = 2,
    parameter int PLAYER_W     = 32,
    parameter int PLAYER_H     = 32,
    parameter int START_X      = 304,
    parameter int START_Y      = 224,
    parameter int ENC_THRESH   = 24,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_COUNT  = 3,
    parameter int GRACE_FRAMES = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [3:0] key_dir,
    input  logic       battle_done,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [3:0] PlayerInput,
    output logic       Wild_Grass_Player_on,
    output logic       Start_Wild_Battle
);
    // state  | meaning
    // ROAM   | keys move the sprite each frame; moving through grass may start an encounter
    // FLASH  | alternating black/clear phases ahead of the battle, sprite frozen
    // BATTLE | battle screen up until the battle engine reports done

    typedef enum logic [1:0] {ROAM, FLASH, BATTLE} state_t;

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_MAX  = 11'(640 - PLAYER_W);
    localparam logic signed [10:0] Y_MAX  = 11'(480 - PLAYER_H);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [3:0] PHASE_LAST = 4'(2 * FLASH_COUNT - 2);
    localparam logic [7:0] GRACE_LOAD = 8'(GRACE_FRAMES);
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

    state_t state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [3:0] face_q, face_d;
    logic       wg_q, wg_d, sb_q, sb_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic [3:0] phase_q, phase_d;
    logic [7:0] grace_q, grace_d;
    logic [7:0] lfsr_q, lfsr_d;

    logic signed [10:0] dx, dy, sum_x, sum_y, nx, ny;
    logic [3:0]  dir;
    logic [10:0] foot_x, foot_y;
    logic        moved, in_grass, lfsr_hit, encounter;

    always_comb begin
        dx  = '0;
        dy  = '0;
        dir = '0;
        if (key_dir[0]) begin
            dy  = STEP_S;
            dir = 4'b0001;
        end else if (key_dir[1]) begin
            dx  = -STEP_S;
            dir = 4'b0010;
        end else if (key_dir[2]) begin
            dx  = STEP_S;
            dir = 4'b0100;
        end else if (key_dir[3]) begin
            dy  = -STEP_S;
            dir = 4'b1000;
        end
    end

    // Signed 11-bit sums so a step off the left/top edge clamps instead of wrapping.
    assign sum_x = $signed({1'b0, x_q}) + dx;
    assign sum_y = $signed({1'b0, y_q}) + dy;

    always_comb begin
        nx = sum_x;
        if (sum_x < 11'sd0)      nx = '0;
        else if (sum_x > X_MAX)  nx = X_MAX;
        ny = sum_y;
        if (sum_y < 11'sd0)      ny = '0;
        else if (sum_y > Y_MAX)  ny = Y_MAX;
    end

    assign foot_x   = unsigned'(nx) + 11'(PLAYER_W / 2);
    assign foot_y   = unsigned'(ny) + 11'(PLAYER_H - 1);
    assign in_grass = (foot_x < 11'd32  && foot_y >= 11'd320) ||
                      (foot_x < 11'd64  && foot_y >= 11'd352) ||
                      (foot_x < 11'd96  && foot_y >= 11'd384) ||
                      (foot_x < 11'd128 && foot_y >= 11'd416) ||
                      (foot_x < 11'd160 && foot_y >= 11'd448);

    assign moved     = (nx[9:0] != x_q) || (ny[9:0] != y_q);
    assign lfsr_hit  = {24'd0, lfsr_q} < 32'(ENC_THRESH);
    assign encounter = moved && in_grass && (grace_q == 8'd0) && lfsr_hit;
    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        face_d      = face_q;
        wg_d        = wg_q;
        sb_d        = sb_q;
        flash_cnt_d = flash_cnt_q;
        phase_d     = phase_q;
        grace_d     = grace_q;
        case (state_q)
            ROAM: begin
                if (frame_tick) begin
                    x_d     = nx[9:0];
                    y_d     = ny[9:0];
                    grace_d = (grace_q == 8'd0) ? 8'd0 : grace_q - 8'd1;
                    if (dir != 4'b0000) face_d = dir;
                    if (encounter) begin
                        state_d     = FLASH;
                        flash_cnt_d = '0;
                        phase_d     = '0;
                        wg_d        = 1'b1;
                    end
                end
            end
            FLASH: begin
                if (frame_tick) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = '0;
                        if (phase_q == PHASE_LAST) begin
                            state_d = BATTLE;
                            wg_d    = 1'b0;
                            sb_d    = 1'b1;
                        end else begin
                            phase_d = phase_q + 4'd1;
                            wg_d    = ~wg_q;
                        end
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                end
            end
            BATTLE: begin
                if (battle_done) begin
                    state_d = ROAM;
                    sb_d    = 1'b0;
                    grace_d = GRACE_LOAD;
                end
            end
            default: state_d = ROAM;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ROAM;
            x_q         <= 10'(START_X);
            y_q         <= 10'(START_Y);
            face_q      <= '0;
            wg_q        <= 1'b0;
            sb_q        <= 1'b0;
            flash_cnt_q <= '0;
            phase_q     <= '0;
            grace_q     <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            face_q      <= face_d;
            wg_q        <= wg_d;
            sb_q        <= sb_d;
            flash_cnt_q <= flash_cnt_d;
            phase_q     <= phase_d;
            grace_q     <= grace_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign PlayerX              = x_q;
    assign PlayerY              = y_q;
    assign PlayerInput          = face_q;
    assign Wild_Grass_Player_on = wg_q;
    assign Start_Wild_Battle    = sb_q;

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: two instances (forced and default encounter threshold)
// driven identically and compared every cycle against a frame-level reference model.
module tb_player_controller;
    localparam int M_ROAM = 0, M_FLASH = 1, M_BATTLE = 2;

    typedef struct {
        int         x, y, face, mode, elapsed, grace;
        logic [7:0] lfsr;
    } mdl_t;

    logic       Clk = 1'b0;
    logic       rst_n, ft, bd;
    logic [3:0] kd;
    logic [9:0] ax, ay, bx, by;
    logic [3:0] ai, bi;
    logic       awg, asb, bwg, bsb;

    int   n_chk = 0;
    int   n_err = 0;
    mdl_t ma, mb;

    always #5 Clk = ~Clk;

    player_controller #(.ENC_THRESH(256)) u_dut_a (
        .Clk(Clk), .Reset_n(rst_n), .frame_tick(ft), .key_dir(kd), .battle_done(bd),
        .PlayerX(ax), .PlayerY(ay), .PlayerInput(ai),
        .Wild_Grass_Player_on(awg), .Start_Wild_Battle(asb)
    );

    player_controller #(.START_X(305), .START_Y(225)) u_dut_b (
        .Clk(Clk), .Reset_n(rst_n), .frame_tick(ft), .key_dir(kd), .battle_done(bd),
        .PlayerX(bx), .PlayerY(by), .PlayerInput(bi),
        .Wild_Grass_Player_on(bwg), .Start_Wild_Battle(bsb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(int sx, int sy);
        mdl_t m;
        m.x = sx; m.y = sy; m.face = 0; m.mode = M_ROAM;
        m.elapsed = 0; m.grace = 0; m.lfsr = 8'hA5;
        return m;
    endfunction

    function automatic bit grass(int fx, int fy);
        if (fy < 320) return 1'b0;
        return fx < 32 * ((fy - 320) / 32 + 1);
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int thresh, logic f, logic b, logic [3:0] k);
        int dx = 0, dy = 0, nx, ny;
        bit hit;
        if (m.mode == M_ROAM && f) begin
            if (k[0])      begin dy =  2; m.face = 1; end
            else if (k[1]) begin dx = -2; m.face = 2; end
            else if (k[2]) begin dx =  2; m.face = 4; end
            else if (k[3]) begin dy = -2; m.face = 8; end
            nx  = clampi(m.x + dx, 608);
            ny  = clampi(m.y + dy, 448);
            hit = (nx != m.x || ny != m.y) && grass(nx + 16, ny + 31)
                  && m.grace == 0 && int'(m.lfsr) < thresh;
            m.x = nx;
            m.y = ny;
            if (m.grace > 0) m.grace--;
            if (hit) begin
                m.mode    = M_FLASH;
                m.elapsed = 0;
            end
        end else if (m.mode == M_FLASH && f) begin
            m.elapsed++;
            if (m.elapsed == 40) m.mode = M_BATTLE;
        end else if (m.mode == M_BATTLE && b) begin
            m.mode  = M_ROAM;
            m.grace = 16;
        end
        m.lfsr = {m.lfsr[6:0], ^(m.lfsr & 8'hB8)};
        return m;
    endfunction

    function automatic logic exp_wg(mdl_t m);
        return m.mode == M_FLASH && ((m.elapsed / 8) % 2 == 0);
    endfunction

    task automatic check_all();
        chk("a_x",  ax,  ma.x);
        chk("a_y",  ay,  ma.y);
        chk("a_pi", ai,  ma.face);
        chk("a_wg", awg, exp_wg(ma));
        chk("a_sb", asb, ma.mode == M_BATTLE);
        chk("b_x",  bx,  mb.x);
        chk("b_y",  by,  mb.y);
        chk("b_pi", bi,  mb.face);
        chk("b_wg", bwg, exp_wg(mb));
        chk("b_sb", bsb, mb.mode == M_BATTLE);
    endtask

    task automatic clk1(input logic f, input logic b, input logic [3:0] k);
        ft = f; bd = b; kd = k;
        @(posedge Clk);
        if (rst_n) begin
            ma = mdl_step(ma, 256, f, b, k);
            mb = mdl_step(mb, 24, f, b, k);
        end
        @(negedge Clk);
        ft = 1'b0; bd = 1'b0;
        check_all();
    endtask

    task automatic tick(input logic [3:0] k, input logic b);
        int idle;
        clk1(1'b1, b, k);
        idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) clk1(1'b0, 1'b0, k);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ax"}, ax, 304);
        chk({tag, "_ay"}, ay, 224);
        chk({tag, "_ai"}, ai, 0);
        chk({tag, "_awg"}, awg, 0);
        chk({tag, "_asb"}, asb, 0);
        chk({tag, "_bx"}, bx, 305);
        chk({tag, "_by"}, by, 225);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ft = 1'b0; bd = 1'b0; kd = 4'b0000;
        ma = mdl_reset(304, 224);
        mb = mdl_reset(305, 225);
        repeat (2) @(negedge Clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) tick(4'b0100, 1'b0);
        chk("d10_x", ax, 324);
        chk("d10_y", ay, 224);
        chk("d10_pi", ai, 4'b0100);

        tick(4'b1111, 1'b0);
        chk("all_x", ax, 324);
        chk("all_y", ay, 226);
        chk("all_pi", ai, 4'b0001);

        tick(4'b0000, 1'b0);
        chk("nokey_pi", ai, 4'b0001);

        for (int i = 0; i < 170; i++) tick(4'b0010, 1'b0);
        chk("clamp_x", ax, 0);
        chk("clamp_pi", ai, 4'b0010);

        for (int i = 0; i < 60 && ma.mode == M_ROAM; i++) tick(4'b0001, 1'b0);
        chk("enc_wg", awg, 1'b1);
        chk("enc_y", ay, 290);

        for (int k = 1; k <= 40; k++) begin
            tick(4'b0001, k == 5);
            chk("flash_wg", awg, (k < 40) && ((k / 8) % 2 == 0));
            chk("flash_sb", asb, k == 40);
            chk("flash_y", ay, 290);
            chk("flash_pi", ai, 4'b0001);
        end

        for (int i = 0; i < 5; i++) tick(4'b0010, 1'b0);
        chk("battle_sb", asb, 1'b1);
        chk("battle_x", ax, 0);

        clk1(1'b1, 1'b1, 4'b0001);
        chk("exit_sb", asb, 1'b0);
        chk("exit_y", ay, 290);

        for (int i = 1; i <= 16; i++) begin
            tick(4'b0001, 1'b0);
            chk("grace_wg", awg, 1'b0);
        end
        tick(4'b0001, 1'b0);
        chk("grace_enc", awg, 1'b1);
        chk("grace_y", ay, 324);

        for (int i = 0; i < 3; i++) tick(4'b0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        ma = mdl_reset(304, 224);
        mb = mdl_reset(305, 225);
        @(negedge Clk);
        rst_n = 1'b1;
        tick(4'b0100, 1'b0);
        chk("first_tick_x", ax, 306);

        for (int i = 0; i < 1500; i++)
            clk1(1'(($urandom_range(0, 1))), $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
